// File: rtl/input_cond_pkg.sv
// Shared constants and elaboration-time helpers for the input conditioning path
// and for other blocks that need the 1 ms tick divisor.
package input_cond_pkg;

   localparam int MS_PER_S = 1000;

   function automatic int clog2(input int value);
      int r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic int tick_div(input int clk_freq);
      return clk_freq / MS_PER_S;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: accepts a new level only after it has been held across
// DEBOUNCE_MS consecutive ms ticks, and flags the direction of each accepted change.
module debounce_channel
   import input_cond_pkg::*;
#(
   parameter int DEBOUNCE_MS = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_bit,
   input  logic tick,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W    = clog2(DEBOUNCE_MS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_dout;
   logic             r_rise;
   logic             r_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_dout <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         // Returning to the stable level restarts the window from zero.
         if (sync_bit == r_dout) begin
            r_cnt <= '0;
         end else if (tick) begin
            if (r_cnt == CNT_LAST) begin
               r_dout <= sync_bit;
               r_cnt  <= '0;
               r_rise <= sync_bit;
               r_fall <= ~sync_bit;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign dout = r_dout;
   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises raw pad levels, debounces each bit against a shared 1 ms tick,
// and reports accepted changes as one-cycle rise/fall pulses.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int CLK_FREQ    = 100000,
   parameter int DEBOUNCE_MS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int                 TICK_DIV   = tick_div(CLK_FREQ);
   localparam int                 PRESC_W    = clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [WIDTH-1:0]   r_sync1;
   logic [WIDTH-1:0]   r_sync2;
   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;

   assign w_tick = (r_presc == PRESC_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_presc <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_MS(DEBOUNCE_MS)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .sync_bit(r_sync2[i]),
         .tick    (w_tick),
         .dout    (dout[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed stimulus against a timestamp-based debounce model;
// predicted change events are queued and matched by an independent monitor.
module tb_input_conditioner;

   localparam int W        = 8;
   localparam int CLK_FREQ = 4000;
   localparam int D        = 3;
   localparam int T        = CLK_FREQ / 1000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout, rise, fall;
   logic         changed;

   input_conditioner #(
      .WIDTH(W), .CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(D)
   ) dut (
      .clk(clk), .rst(rst), .din(din),
      .dout(dout), .rise(rise), .fall(fall), .changed(changed)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic [W-1:0] dout;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;
   int  mcyc   = 0;

   always @(posedge clk) mcyc <= mcyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, mcyc, act, exp);
      end
   endtask

   // Reference model: edge index since reset release, two-edge input delay,
   // and the edge at which each channel's current mismatch began.
   int           n;
   logic [W-1:0] p1, p2;
   logic [W-1:0] mdout;
   int           mstart [W];

   function automatic void model_reset();
      n = 0; p1 = '0; p2 = '0; mdout = '0;
      for (int i = 0; i < W; i++) mstart[i] = -1;
   endfunction

   function automatic void model_edge(input logic [W-1:0] d, input int tag);
      logic [W-1:0] syncv, rm, fm;
      int ticks;
      syncv = p2; p2 = p1; p1 = d;
      rm = '0; fm = '0;
      for (int i = 0; i < W; i++) begin
         if (syncv[i] == mdout[i]) mstart[i] = -1;
         else begin
            if (mstart[i] < 0) mstart[i] = n;
            // ticks fall on edges with n % T == T-1
            ticks = (n + 1) / T - mstart[i] / T;
            if (ticks >= D) begin
               mdout[i] = syncv[i];
               if (syncv[i]) rm[i] = 1'b1; else fm[i] = 1'b1;
               mstart[i] = -1;
            end
         end
      end
      if ((rm | fm) != '0) q.push_back('{tag, mdout, rm, fm});
      n++;
   endfunction

   task automatic step(input logic [W-1:0] d, input logic r);
      @(negedge clk); #1;
      din = d; rst = r;
      if (r) model_reset();
      else   model_edge(d, mcyc + 1);
   endtask

   task automatic hold(input logic [W-1:0] d, input int cycles);
      for (int k = 0; k < cycles; k++) step(d, 1'b0);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {7'd0, changed, fall, rise, dout}, 32'd0);
      end else begin
         chk("changed_or", {31'd0, changed}, {31'd0, |(rise | fall)});
         if ((rise & fall) != '0) chk("rise_fall_excl", {24'd0, rise & fall}, 32'd0);
         while (q.size() > 0 && q[0].cyc < mcyc) begin
            chk("missed_event_cyc", q[0].cyc, mcyc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].cyc == mcyc) begin
            chk("ev_changed", {31'd0, changed}, 32'd1);
            chk("ev_dout", {24'd0, dout}, {24'd0, q[0].dout});
            chk("ev_rise", {24'd0, rise}, {24'd0, q[0].rise});
            chk("ev_fall", {24'd0, fall}, {24'd0, q[0].fall});
            void'(q.pop_front());
         end else if (changed || rise != '0 || fall != '0) begin
            chk("unexpected_pulse", {7'd0, changed, fall, rise, dout}, 32'd0);
         end
      end
   end

   logic [W-1:0] cur;

   initial begin
      model_reset();
      // Reset held with all pins high, then release
      for (int k = 0; k < 5; k++) step(8'hFF, 1'b1);
      hold(8'hFF, 20);
      hold(8'h00, 20);
      // Clean step on bit 0
      hold(8'h01, 20);
      hold(8'h00, 20);
      // Bounce on bit 3, settling high
      for (int b = 0; b < 4; b++) hold((b % 2 == 0) ? 8'h08 : 8'h00, 5);
      hold(8'h08, 20);
      hold(8'h00, 20);
      // Short glitch on bit 5
      hold(8'h20, 6);
      hold(8'h00, 20);
      // Simultaneous rise, then a single fall
      hold(8'h81, 20);
      hold(8'h01, 20);
      hold(8'h00, 20);
      // Reset mid-window on bit 1
      hold(8'h02, 6);
      step(8'h02, 1'b1);
      step(8'h02, 1'b1);
      hold(8'h02, 20);
      hold(8'h00, 20);
      // Random segments with occasional resets
      cur = '0;
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            step(cur, 1'b1);
            step(cur, 1'b1);
         end
         if ($urandom_range(0, 3) == 0) cur = W'($urandom);
         else                          cur = cur ^ (W'(1) << $urandom_range(0, W - 1));
         hold(cur, $urandom_range(1, 18));
      end
      hold(cur, 20);
      @(negedge clk); #2;
      chk("pending_events", q.size(), 0);
      chk("final_dout", {24'd0, dout}, {24'd0, mdout});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
